// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared opcode constants, controller state encoding and datapath select enums
// for the multi-cycle RV32I control unit.
package multi_cycle_control_unit_pkg;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PC_INC = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_FUNCT  = 2'd1,
    ALU_BRANCH = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'd0,
    SRCB_FOUR = 2'd1,
    SRCB_IMM  = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_ALU    = 2'd2
  } wb_sel_e;

  // Opcodes that take the EX path; anything else decodes as a NOP.
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_ARITH) || (op == OP_ARITH_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_mc_next_state.sv
// Pure combinational next-state function of the multi-cycle controller.
module mc_next_state
  import multi_cycle_control_unit_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output state_e     next_state
);

  always_comb begin
    next_state = state;
    case (state)
      S_IF: begin
        if (mem_ready) next_state = S_ID;
      end
      S_ID: begin
        if (opcode == OP_ECALL)   next_state = halt_req ? S_HALT : S_PC_INC;
        else if (is_exec_op(opcode)) next_state = S_EX;
        else                      next_state = S_PC_INC;
      end
      S_EX: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM;
          OP_BRANCH:         next_state = alu_bcond ? S_IF : S_PC_INC;
          default:           next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) next_state = (opcode == OP_LOAD) ? S_WB : S_PC_INC;
      end
      S_WB:     next_state = S_IF;
      S_PC_INC: next_state = S_IF;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I controller: state register, per-state datapath control
// decode and retired-instruction counter.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic                 alu_bcond,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  output logic                 pc_write,
  output logic                 pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 is_ecall,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_count
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_count_q, retired_count_d;
  logic                 retire;

  mc_next_state u_next_state (
    .state      (state_q),
    .opcode     (opcode),
    .alu_bcond  (alu_bcond),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .next_state (state_d)
  );

  // Only EX-to-IF for a taken branch, WB and PC_INC complete an instruction.
  always_comb begin
    retire = (state_d == S_IF) &&
             ((state_q == S_WB) || (state_q == S_PC_INC) || (state_q == S_EX));
    retired_count_d = retired_count_q + {{(CNT_WIDTH-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IF;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;

  always_comb begin
    pc_write  = 1'b0;
    pc_source = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    alu_op    = ALU_ADD;
    is_ecall  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_ID: begin
        alu_src_b = SRCB_IMM;
        is_ecall  = (opcode == OP_ECALL);
      end
      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
          end
          OP_ARITH_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_BRANCH;
            pc_write  = alu_bcond;
            pc_source = alu_bcond;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        // ALU computes PC+4 here; jumps take the target held in ALUOut.
        reg_write = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        case (opcode)
          OP_LOAD: wb_sel = WB_MDR;
          OP_JAL, OP_JALR: begin
            wb_sel    = WB_ALU;
            pc_source = 1'b1;
          end
          default: wb_sel = WB_ALUOUT;
        endcase
      end
      S_PC_INC: begin
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench: directed per-cycle vectors push expected controls; a
// negedge monitor pops and compares both a 32-bit and a 2-bit-counter instance.
module tb_multi_cycle_control_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       alu_bcond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;

  logic pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op;
  logic alu_src_a, is_ecall, halted;
  logic [31:0] retired_count;

  logic pc_write2, pc_source2, i_or_d2, mem_read2, mem_write2, ir_write2, reg_write2;
  logic [1:0] wb_sel2, alu_src_b2, alu_op2;
  logic alu_src_a2, is_ecall2, halted2;
  logic [1:0] retired_count2;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
    .mem_ready(mem_ready), .halt_req(halt_req), .pc_write(pc_write),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_ecall(is_ecall), .halted(halted),
    .retired_count(retired_count)
  );

  multi_cycle_control_unit #(.CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
    .mem_ready(mem_ready), .halt_req(halt_req), .pc_write(pc_write2),
    .pc_source(pc_source2), .i_or_d(i_or_d2), .mem_read(mem_read2),
    .mem_write(mem_write2), .ir_write(ir_write2), .reg_write(reg_write2),
    .wb_sel(wb_sel2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .alu_op(alu_op2), .is_ecall(is_ecall2), .halted(halted2),
    .retired_count(retired_count2)
  );

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, EC = 7'b1110011, BAD = 7'b0000000;

  // {pc_write,pc_source,i_or_d,mem_read,mem_write,ir_write,reg_write,
  //  wb_sel[1:0],alu_src_a,alu_src_b[1:0],alu_op[1:0],is_ecall,halted}
  function automatic logic [15:0] ev(input logic pcw, input logic pcs,
      input logic iod, input logic mr, input logic mw, input logic irw,
      input logic rw, input logic [1:0] wb, input logic sa, input logic [1:0] sb,
      input logic [1:0] op, input logic ec, input logic h);
    return {pcw, pcs, iod, mr, mw, irw, rw, wb, sa, sb, op, ec, h};
  endfunction

  localparam logic [15:0]
    E_IF_WAIT = {7'b0001000, 2'd0, 1'b0, 2'd0, 2'd0, 2'b00},
    E_IF_RDY  = {7'b0001010, 2'd0, 1'b0, 2'd0, 2'd0, 2'b00};
  logic [15:0] E_ID, E_ID_EC, E_EX_R, E_EX_I, E_EX_LS, E_EX_JAL, E_EX_BT,
               E_EX_BN, E_MEM_LD, E_MEM_ST, E_WB_ALU, E_WB_LD, E_WB_J,
               E_PCINC, E_HALT;

  typedef struct {
    string       name;
    logic [15:0] ctl;
    int          cnt;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  function automatic logic [15:0] actual_ctl();
    return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
            reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall, halted};
  endfunction

  function automatic logic [15:0] actual_ctl2();
    return {pc_write2, pc_source2, i_or_d2, mem_read2, mem_write2, ir_write2,
            reg_write2, wb_sel2, alu_src_a2, alu_src_b2, alu_op2, is_ecall2, halted2};
  endfunction

  // Monitor: compare whatever the stimulus side expects for this cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [1:0] c2;
      e = sb_q.pop_front();
      c2 = e.cnt[1:0];
      checks++;
      if (actual_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %016b expected %016b", e.name, actual_ctl(), e.ctl);
      end
      checks++;
      if (retired_count !== e.cnt) begin
        errors++;
        $display("FAIL %s retired_count: got %0d expected %0d", e.name, retired_count, e.cnt);
      end
      checks++;
      if (actual_ctl2() !== e.ctl || retired_count2 !== c2) begin
        errors++;
        $display("FAIL %s w2 instance: ctl %016b cnt %0d expected %016b cnt %0d",
                 e.name, actual_ctl2(), retired_count2, e.ctl, c2);
      end
    end
  end

  // One clock cycle of stimulus; chk=0 skips the expectation (unknown state).
  task automatic step(input string name, input logic [6:0] op, input logic rdy,
                      input logic bc, input logic hr, input logic rn,
                      input logic chk, input logic [15:0] ctl);
    exp_t e;
    opcode = op; mem_ready = rdy; alu_bcond = bc; halt_req = hr; reset_n = rn;
    if (chk) begin
      e.name = name; e.ctl = ctl; e.cnt = exp_cnt;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    E_ID     = ev(0,0,0,0,0,0,0,2'd0,0,2'd2,2'd0,0,0);
    E_ID_EC  = ev(0,0,0,0,0,0,0,2'd0,0,2'd2,2'd0,1,0);
    E_EX_R   = ev(0,0,0,0,0,0,0,2'd0,1,2'd0,2'd1,0,0);
    E_EX_I   = ev(0,0,0,0,0,0,0,2'd0,1,2'd2,2'd1,0,0);
    E_EX_LS  = ev(0,0,0,0,0,0,0,2'd0,1,2'd2,2'd0,0,0);
    E_EX_JAL = ev(0,0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    E_EX_BT  = ev(1,1,0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0);
    E_EX_BN  = ev(0,0,0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0);
    E_MEM_LD = ev(0,0,1,1,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    E_MEM_ST = ev(0,0,1,0,1,0,0,2'd0,0,2'd0,2'd0,0,0);
    E_WB_ALU = ev(1,0,0,0,0,0,1,2'd0,0,2'd1,2'd0,0,0);
    E_WB_LD  = ev(1,0,0,0,0,0,1,2'd1,0,2'd1,2'd0,0,0);
    E_WB_J   = ev(1,1,0,0,0,0,1,2'd2,0,2'd1,2'd0,0,0);
    E_PCINC  = ev(1,0,0,0,0,0,0,2'd0,0,2'd1,2'd0,0,0);
    E_HALT   = ev(0,0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1);

    @(posedge clk); #1;
    step("rst0", BAD, 0, 0, 0, 0, 0, '0);
    step("rst1", BAD, 0, 0, 0, 0, 0, '0);

    // Reset then idle: IF held while memory is busy
    for (int i = 0; i < 3; i++) step("if_wait", R, 0, 0, 0, 1, 1, E_IF_WAIT);
    step("r_if",  R, 1, 0, 0, 1, 1, E_IF_RDY);
    step("r_id",  R, 0, 0, 0, 1, 1, E_ID);
    step("r_ex",  R, 0, 0, 0, 1, 1, E_EX_R);
    step("r_wb",  R, 0, 0, 0, 1, 1, E_WB_ALU); exp_cnt = 1;

    step("i_if",  I, 1, 0, 0, 1, 1, E_IF_RDY);
    step("i_id",  I, 1, 0, 0, 1, 1, E_ID);
    step("i_ex",  I, 1, 0, 0, 1, 1, E_EX_I);
    step("i_wb",  I, 1, 0, 0, 1, 1, E_WB_ALU); exp_cnt = 2;

    // LOAD with two wait cycles in MEM
    step("ld_if",  LD, 1, 0, 0, 1, 1, E_IF_RDY);
    step("ld_id",  LD, 0, 0, 0, 1, 1, E_ID);
    step("ld_ex",  LD, 0, 0, 0, 1, 1, E_EX_LS);
    step("ld_mw0", LD, 0, 0, 0, 1, 1, E_MEM_LD);
    step("ld_mw1", LD, 0, 0, 0, 1, 1, E_MEM_LD);
    step("ld_mem", LD, 1, 0, 0, 1, 1, E_MEM_LD);
    step("ld_wb",  LD, 0, 0, 0, 1, 1, E_WB_LD); exp_cnt = 3;

    step("bt_if", BR, 1, 0, 0, 1, 1, E_IF_RDY);
    step("bt_id", BR, 0, 1, 0, 1, 1, E_ID);
    step("bt_ex", BR, 0, 1, 0, 1, 1, E_EX_BT); exp_cnt = 4;

    step("bn_if",  BR, 1, 0, 0, 1, 1, E_IF_RDY);
    step("bn_id",  BR, 0, 0, 0, 1, 1, E_ID);
    step("bn_ex",  BR, 0, 0, 0, 1, 1, E_EX_BN);
    step("bn_inc", BR, 0, 0, 0, 1, 1, E_PCINC); exp_cnt = 5;

    step("st_if",  ST, 1, 0, 0, 1, 1, E_IF_RDY);
    step("st_id",  ST, 0, 0, 0, 1, 1, E_ID);
    step("st_ex",  ST, 0, 0, 0, 1, 1, E_EX_LS);
    step("st_mem", ST, 1, 0, 0, 1, 1, E_MEM_ST);
    step("st_inc", ST, 0, 0, 0, 1, 1, E_PCINC); exp_cnt = 6;

    step("jal_if", JAL, 1, 0, 0, 1, 1, E_IF_RDY);
    step("jal_id", JAL, 0, 0, 0, 1, 1, E_ID);
    step("jal_ex", JAL, 0, 0, 0, 1, 1, E_EX_JAL);
    step("jal_wb", JAL, 0, 0, 0, 1, 1, E_WB_J); exp_cnt = 7;

    step("jalr_if", JALR, 1, 0, 0, 1, 1, E_IF_RDY);
    step("jalr_id", JALR, 0, 0, 0, 1, 1, E_ID);
    step("jalr_ex", JALR, 0, 0, 0, 1, 1, E_EX_LS);
    step("jalr_wb", JALR, 0, 0, 0, 1, 1, E_WB_J); exp_cnt = 8;

    step("nop_if",  BAD, 1, 0, 0, 1, 1, E_IF_RDY);
    step("nop_id",  BAD, 0, 0, 0, 1, 1, E_ID);
    step("nop_inc", BAD, 0, 0, 0, 1, 1, E_PCINC); exp_cnt = 9;

    step("ec_if",  EC, 1, 0, 0, 1, 1, E_IF_RDY);
    step("ec_id",  EC, 0, 0, 0, 1, 1, E_ID_EC);
    step("ec_inc", EC, 0, 0, 0, 1, 1, E_PCINC); exp_cnt = 10;

    // Halting ECALL: terminal, counter frozen, inputs ignored
    step("eh_if", EC, 1, 0, 1, 1, 1, E_IF_RDY);
    step("eh_id", EC, 0, 0, 1, 1, 1, E_ID_EC);
    step("halt0", R,  1, 1, 0, 1, 1, E_HALT);
    step("halt1", BR, 1, 1, 1, 1, 1, E_HALT);
    step("halt2", LD, 0, 0, 0, 1, 1, E_HALT);
    step("halt_rst", EC, 1, 0, 1, 0, 1, E_HALT); exp_cnt = 0;
    step("post_rst", ST, 0, 0, 0, 1, 1, E_IF_WAIT);

    // Reset abandons a STORE waiting in MEM
    step("mr_if",  ST, 1, 0, 0, 1, 1, E_IF_RDY);
    step("mr_id",  ST, 0, 0, 0, 1, 1, E_ID);
    step("mr_ex",  ST, 0, 0, 0, 1, 1, E_EX_LS);
    step("mr_mw",  ST, 0, 0, 0, 1, 1, E_MEM_ST);
    step("mr_rst", ST, 0, 0, 0, 0, 1, E_MEM_ST);
    step("mr_if2", ST, 0, 0, 0, 1, 1, E_IF_WAIT);
    step("mr_if3", ST, 0, 0, 0, 1, 1, E_IF_WAIT);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Finite-state controller that sequences the shared ALU, register file, and unified instruction/data memory of the multi-cycle RV32I core, one architectural step per state. Each cycle it decodes the latched opcode and the current state into datapath mux selects and write enables. It waits on a memory ready handshake and stops permanently on a halting ECALL. It replaces the single-cycle combinational decoder in the multi-cycle build.

## Interface
- CNT_WIDTH, 32, width of the retired-instruction counter
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- opcode  input  7  IR[6:0] of the latched instruction
- alu_bcond  input  1  branch condition from the ALU, valid in EX for BRANCH
- mem_ready  input  1  memory has completed the current read/write this cycle
- halt_req  input  1  ECALL halt condition (x17 == 10), valid in ID
- pc_write  output  1  load PC this cycle
- pc_source  output  1  0: ALU result, 1: ALUOut register
- i_or_d  output  1  memory address select; 0: PC, 1: ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  latch the memory read data into IR
- reg_write  output  1  register-file write enable
- wb_sel  output  2  write-back data; 0: ALUOut, 1: MDR, 2: ALU result
- alu_src_a  output  1  0: PC, 1: register A
- alu_src_b  output  2  0: register B, 1: constant 4, 2: immediate
- alu_op  output  2  0: ADD, 1: FUNCT (decoded by the ALU control), 2: BRANCH compare
- is_ecall  output  1  ECALL is decoded in ID
- halted  output  1  controller is in the HALT state
- retired_count  output  CNT_WIDTH  number of instructions completed

## Operation
States: IF, ID, EX, MEM, WB, PC_INC, HALT. Unless a state lists otherwise, every output is 0.

- **IF**
  - Drives mem_read=1, i_or_d=0.
  - If mem_ready: ir_write=1, next state ID. Otherwise stay in IF.
- **ID**
  - Drives alu_src_a=0, alu_src_b=2, alu_op=ADD, so ALUOut captures PC+imm.
  - ECALL: is_ecall=1. Next state HALT if halt_req, else PC_INC.
  - Unknown opcode: next state PC_INC (the instruction executes as a NOP).
  - All other opcodes: next state EX.
- **EX**
  - ARITHMETIC: src_a=1, src_b=0, alu_op=FUNCT. Next state WB.
  - ARITHMETIC_IMM: src_a=1, src_b=2, alu_op=FUNCT. Next state WB.
  - LOAD / STORE: src_a=1, src_b=2, alu_op=ADD. Next state MEM.
  - JALR: src_a=1, src_b=2, alu_op=ADD. Next state WB.
  - JAL: no ALU use. Next state WB.
  - BRANCH: src_a=1, src_b=0, alu_op=BRANCH.
    - If alu_bcond: pc_write=1, pc_source=1, next state IF.
    - Otherwise: next state PC_INC.
- **MEM**
  - Drives i_or_d=1.
  - LOAD: mem_read=1. STORE: mem_write=1.
  - Hold until mem_ready; then LOAD goes to WB and STORE goes to PC_INC.
- **WB**
  - Drives reg_write=1, src_a=0, src_b=1, alu_op=ADD, so the ALU result is PC+4. Also pc_write=1.
  - ARITHMETIC / ARITHMETIC_IMM: wb_sel=0, pc_source=0.
  - LOAD: wb_sel=1, pc_source=0.
  - JAL / JALR: wb_sel=2 (rd receives PC+4), pc_source=1 (PC receives ALUOut).
  - Next state IF.
- **PC_INC**
  - Drives src_a=0, src_b=1, alu_op=ADD, pc_write=1, pc_source=0.
  - Next state IF.
- **HALT**
  - halted=1 and every other control output is 0.
  - Terminal; only reset leaves it.

Further rules:
- retired_count increments by 1 on every transition into IF from WB, PC_INC, or a taken-branch EX. It wraps modulo 2^CNT_WIDTH. It does not increment on entry to HALT.
- mem_ready is ignored outside IF and MEM.
- Opcode and halt_req are sampled only in the states listed above.

## Timing
- Reset: when reset_n is low at a clock edge, state becomes IF and retired_count becomes 0. This applies in every state, including mid-MEM and HALT.
  - During the first cycle after reset the controller is in IF, so mem_read=1 and i_or_d=0. Every other output is 0.
  - A memory request abandoned by reset is not retried.
- Outputs are combinational from the state register, opcode, mem_ready, and alu_bcond. No output is registered.
- Latency in cycles, with mem_ready high on first request:
  - ARITHMETIC / ARITHMETIC_IMM: 4
  - LOAD: 5
  - STORE: 5
  - JAL / JALR: 4
  - Taken BRANCH: 3
  - Not-taken BRANCH: 4
  - Non-halting ECALL: 3
- Each cycle with mem_ready low in IF or MEM adds one cycle. The request outputs stay stable throughout the wait.

## Structure
- Opcode constants belong in the shared opcodes package: ARITHMETIC 0110011, ARITHMETIC_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- The same package also holds the state encoding and the enums for alu_op, alu_src_b, and wb_sel.
- There is one natural sub-module, `mc_next_state`: a pure combinational next-state function.
- The top level holds the state register, the output decode, and retired_count.

## Test plan
- **Reset then idle:** release reset_n with mem_ready=0 for 3 cycles → state stays IF with mem_read=1 and ir_write=0; on mem_ready=1, ir_write=1 for exactly one cycle.
- **R-type then I-type:** opcode 0110011 → pc_write=1 and reg_write=1 in cycle 4 with wb_sel=0; retired_count=1. Then opcode 0010011 → retired_count=2.
- **LOAD with wait states:** mem_ready low for 2 cycles in MEM → total latency 7; WB asserts wb_sel=1; mem_read is stable throughout MEM.
- **BRANCH:**
  - alu_bcond=1 in EX → pc_write=1, pc_source=1, back in IF after 3 cycles.
  - alu_bcond=0 → PC_INC, 4 cycles.
- **ECALL:**
  - halt_req=1 → halted=1 forever and retired_count frozen.
  - reset_n=0 → IF with retired_count=0.
  - halt_req=0 → PC_INC, count increments.
- **Reset mid-MEM:** reset_n=0 during a STORE wait → next cycle in IF, mem_write=0; counter wrap checked with CNT_WIDTH=2 (four retirements → 0).
